sum_diff_pipe: RTL

Parametrised, back-pressured pipeline front end for the quarter-square LUT multiplier. Per accepted operand pair it produces the exact signed sum and difference, widened to WIDTH+1 bits, plus sign flags. An optional magnitude stage converts both results to the unsigned LUT indices that the square-table stage needs. It sits between the operand source and the square-LUT lookup.

---
 rtl/qsq_pkg.sv | 21 ++
 rtl/qsq_pipe_reg.sv | 43 ++++
 rtl/sum_diff_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/qsq_pkg.sv
// Shared definitions for the quarter-square multiplier datapath.
// Holds the sum/difference width helper and the {neg, value} result
// record consumed by the square-LUT stage.
package qsq_pkg;

   // Width of an exact sum or difference of two w-bit two's-complement operands.
   function automatic int sum_w(input int width);
      return width + 1;
   endfunction

   // Default operand width of the multiplier datapath.
   localparam int QSQ_WIDTH = 8;
   localparam int QSQ_SUM_W = sum_w(QSQ_WIDTH);

   // Result record handed to the square-LUT stage: sign plus value/magnitude.
   typedef struct packed {
      logic                 neg;
      logic [QSQ_SUM_W-1:0] value;
   } qsq_res_t;

endpackage

// File: rtl/qsq_pipe_reg.sv
// Generic valid/ready register slice. One payload register plus a valid
// flag; it loads when empty or when its content leaves in the same cycle,
// so bubbles collapse and a full slice still streams one item per cycle.
module qsq_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid_i,
   output logic         s_ready_o,
   input  logic [W-1:0] s_data_i,
   output logic         m_valid_o,
   input  logic         m_ready_i,
   output logic [W-1:0] m_data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         load;

   // Ready and next-state: accept when empty or when the held item leaves now.
   always_comb begin
      s_ready_o = !rst && (!valid_q || m_ready_i);
      load      = s_valid_i && s_ready_o;
      valid_d   = load ? 1'b1 : (valid_q && !m_ready_i);
      data_d    = load ? s_data_i : data_q;
   end

   // State registers; reset discards any held item.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign m_valid_o = valid_q;
   assign m_data_o  = data_q;

endmodule

// File: rtl/sum_diff_pipe.sv
// Sum/difference front end of the quarter-square LUT multiplier.
// Stage 1 forms the exact WIDTH+1-bit signed sum and difference with sign
// flags. Define SUM_DIFF_ABS_EN to add a second stage that converts both
// results to unsigned magnitudes (LUT indices); flags pass through unchanged.
module sum_diff_pipe
   import qsq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH:0]   sum_o,
   output logic [WIDTH:0]   diff_o,
   output logic             sum_neg_o,
   output logic             diff_neg_o,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int SUM_W = sum_w(WIDTH);

   typedef struct packed {
      logic             neg;
      logic [SUM_W-1:0] value;
   } res_t;

   typedef struct packed {
      res_t sum;
      res_t diff;
   } pair_t;

   localparam int PAIR_W = $bits(pair_t);

   // Sign-extend one operand to the result width.
   function automatic logic signed [SUM_W-1:0] sext(input logic [WIDTH-1:0] x);
      return $signed({x[WIDTH-1], x});
   endfunction

   // Magnitude as unsigned SUM_W bits; -2^WIDTH maps onto 2^WIDTH exactly.
   function automatic logic [SUM_W-1:0] mag(input logic [SUM_W-1:0] v);
      return v[SUM_W-1] ? (~v + 1'b1) : v;
   endfunction

   logic signed [SUM_W-1:0] sum_s_p0, diff_s_p0;
   pair_t                   pair_p0, pair_p1, result;
   logic                    vld_p1;
   logic                    s1_rdy_dn;

   // Stage 1 arithmetic: true widened add and subtract, no WIDTH-bit negation of b.
   always_comb begin
      sum_s_p0           = sext(a_i) + sext(b_i);
      diff_s_p0          = sext(a_i) - sext(b_i);
      pair_p0.sum.neg    = sum_s_p0[SUM_W-1];
      pair_p0.sum.value  = sum_s_p0;
      pair_p0.diff.neg   = diff_s_p0[SUM_W-1];
      pair_p0.diff.value = diff_s_p0;
   end

   qsq_pipe_reg #(.W(PAIR_W)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .s_valid_i (in_valid),
      .s_ready_o (in_ready),
      .s_data_i  (pair_p0),
      .m_valid_o (vld_p1),
      .m_ready_i (s1_rdy_dn),
      .m_data_o  (pair_p1)
   );

`ifdef SUM_DIFF_ABS_EN
   pair_t pair_abs_p1, pair_p2;

   // Stage 2 conversion: magnitudes for LUT indexing, flags carried as-is.
   always_comb begin
      pair_abs_p1.sum.neg    = pair_p1.sum.neg;
      pair_abs_p1.sum.value  = mag(pair_p1.sum.value);
      pair_abs_p1.diff.neg   = pair_p1.diff.neg;
      pair_abs_p1.diff.value = mag(pair_p1.diff.value);
   end

   qsq_pipe_reg #(.W(PAIR_W)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .s_valid_i (vld_p1),
      .s_ready_o (s1_rdy_dn),
      .s_data_i  (pair_abs_p1),
      .m_valid_o (out_valid),
      .m_ready_i (out_ready),
      .m_data_o  (pair_p2)
   );

   assign result = pair_p2;
`else
   assign s1_rdy_dn = out_ready;
   assign out_valid = vld_p1;
   assign result    = pair_p1;
`endif

   assign sum_o      = result.sum.value;
   assign sum_neg_o  = result.sum.neg;
   assign diff_o     = result.diff.value;
   assign diff_neg_o = result.diff.neg;

endmodule
